// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: registered N-way mux with valid/ready handshakes and
// built-in arbitration. Each cycle it picks one requesting channel,
// either round-robin starting after the last winner or by fixed lowest-index
// priority. The winning beat is loaded into a one-entry output register and
// tagged with its source channel index.
module rr_mux_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 prio_mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [IDW-1:0] ptr;
    logic           can_load;
    logic           any_valid;
    logic           grant_hit;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] rr_idx;
    logic [IDW-1:0] rr_cand;
    logic [IDW-1:0] fp_idx;

    assign can_load  = !out_valid || out_ready;
    assign any_valid = |in_valid;

    // Round-robin search: the candidate closest after ptr wins, so the loop
    // walks the offsets from farthest to nearest and the last hit sticks.
    always_comb begin
        rr_idx  = '0;
        rr_cand = '0;
        for (int i = N; i >= 1; i--) begin
            rr_cand = IDW'((int'(ptr) + i) % N);
            if (in_valid[rr_cand]) begin
                rr_idx = rr_cand;
            end
        end
    end

    // Fixed priority: lowest valid index wins, scanned high to low.
    always_comb begin
        fp_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                fp_idx = IDW'(k);
            end
        end
    end

    // Grant qualification; reset forces every in_ready low even though ptr
    // already sits at its reset value.
    assign grant_hit = reset_n && can_load && any_valid;
    assign grant_idx = prio_mode ? fp_idx : rr_idx;

    // One-hot ready towards the winning producer.
    always_comb begin
        in_ready = '0;
        if (grant_hit) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and pointer: load on grant, drain when consumed.
    // ptr follows every winner in both modes so round-robin resumes after it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= IDW'(N - 1);
        end else if (grant_hit) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_id    <= grant_idx;
            ptr       <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
